expr_eval: RTL

EXPR_EVAL -- requirements
Module: expr_eval

---
 rtl/expr_pkg.sv | 25 ++
 rtl/expr_char_class.sv | 25 ++
 rtl/expr_eval.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared types and character constants for the expression evaluator.
package expr_pkg;

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StNum   = 2'd1,
    StOp    = 2'd2,
    StErr   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ClsDigit,
    ClsPlus,
    ClsMul,
    ClsEq,
    ClsOther
  } char_class_e;

  localparam logic [7:0] CharZero = 8'h30;
  localparam logic [7:0] CharNine = 8'h39;
  localparam logic [7:0] CharPlus = 8'h2b;
  localparam logic [7:0] CharMul  = 8'h2a;
  localparam logic [7:0] CharEq   = 8'h3d;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: character class plus the digit value for '0'..'9'.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_e cls,
  output logic [3:0]  digit
);

  always_comb begin
    cls   = ClsOther;
    digit = 4'd0;
    if (ch >= CharZero && ch <= CharNine) begin
      cls   = ClsDigit;
      digit = ch[3:0];
    end else if (ch == CharPlus) begin
      cls = ClsPlus;
    end else if (ch == CharMul) begin
      cls = ClsMul;
    end else if (ch == CharEq) begin
      cls = ClsEq;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit expressions with '+' and '*' ('*' binds tighter).
// Optional sticky overflow flag enabled by defining EXPR_EVAL_OVF_EN.
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         ok,
  output logic         done,
  output logic [1:0]   s
`ifdef EXPR_EVAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  char_class_e  cls;
  logic [3:0]   digit;
  state_e       state_q;
  logic [W-1:0] sum_q, prod_q;
  logic         mul_pend_q;
  logic [W-1:0] dig_w, prod_mul, prod_op, sum_add, res_op;

  expr_char_class u_char_class (
    .ch    (in),
    .cls   (cls),
    .digit (digit)
  );

  assign dig_w   = {{(W-4){1'b0}}, digit};
  assign prod_op = mul_pend_q ? prod_mul : dig_w;
  assign s       = state_q;

`ifdef EXPR_EVAL_OVF_EN
  logic [W+3:0] mul_wide;
  logic         add_c, res_c, mul_c;

  assign mul_wide         = {4'b0, prod_q} * {{W{1'b0}}, digit};
  assign prod_mul         = mul_wide[W-1:0];
  assign mul_c            = mul_pend_q && (|mul_wide[W+3:W]);
  assign {add_c, sum_add} = {1'b0, sum_q} + {1'b0, prod_q};
  assign {res_c, res_op}  = {1'b0, sum_q} + {1'b0, prod_op};
`else
  assign prod_mul = prod_q * dig_w;
  assign sum_add  = sum_q + prod_q;
  assign res_op   = sum_q + prod_op;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StStart;
      sum_q      <= '0;
      prod_q     <= '0;
      mul_pend_q <= 1'b0;
      result     <= '0;
      ok         <= 1'b0;
      done       <= 1'b0;
`ifdef EXPR_EVAL_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (in_valid) begin
        case (state_q)
          StStart: begin
            case (cls)
              ClsDigit: begin
                sum_q      <= '0;
                prod_q     <= dig_w;
                mul_pend_q <= 1'b0;
                result     <= dig_w;
                ok         <= 1'b1;
                state_q    <= StNum;
`ifdef EXPR_EVAL_OVF_EN
                ovf        <= 1'b0;
`endif
              end
              ClsEq: begin
                done   <= 1'b1;
                result <= '0;
                ok     <= 1'b0;
              end
              default: begin
                ok      <= 1'b0;
                state_q <= StErr;
              end
            endcase
          end
          StNum: begin
            case (cls)
              ClsPlus: begin
                sum_q   <= sum_add;
                ok      <= 1'b0;
                state_q <= StOp;
`ifdef EXPR_EVAL_OVF_EN
                if (add_c) ovf <= 1'b1;
`endif
              end
              ClsMul: begin
                mul_pend_q <= 1'b1;
                ok         <= 1'b0;
                state_q    <= StOp;
              end
              // Valid terminator: result and ok stay up through the done cycle.
              ClsEq: begin
                done    <= 1'b1;
                state_q <= StStart;
              end
              default: begin
                ok      <= 1'b0;
                state_q <= StErr;
              end
            endcase
          end
          StOp: begin
            case (cls)
              ClsDigit: begin
                prod_q     <= prod_op;
                mul_pend_q <= 1'b0;
                result     <= res_op;
                ok         <= 1'b1;
                state_q    <= StNum;
`ifdef EXPR_EVAL_OVF_EN
                if (mul_c || res_c) ovf <= 1'b1;
`endif
              end
              ClsEq: begin
                done    <= 1'b1;
                ok      <= 1'b0;
                state_q <= StErr;
              end
              default: begin
                ok      <= 1'b0;
                state_q <= StErr;
              end
            endcase
          end
          default: begin
            if (cls == ClsEq) begin
              done    <= 1'b1;
              state_q <= StStart;
            end
          end
        endcase
      end
    end
  end

endmodule
